seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter N_DIG, default 2, number of multiplexed digits (legal 2..8).
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot (DIV > BLANK).
REQ-003 Parameter BLANK, default 16, dead-time cycles at the start of each slot (legal BLANK >= 1).
REQ-004 Parameter ACTIVE_LOW, default 1; 1 = segments and digit selects driven low-active, 0 = high-active.
REQ-005 Clk  in  1  single clock; all logic on rising edge.
REQ-006 Rst_n  in  1  reset, synchronous, active-low.
REQ-007 Seg_In  in  7*N_DIG  logical segment patterns (1 = segment lit), digit k at bits [7k+6:7k], bit order g..a as the seven-seg decoder drives.
REQ-008 Load  in  1  capture strobe for Seg_In.
REQ-009 Enable  in  1  scan enable; low = display dark.
REQ-010 Seg_Out  out  7  physical segment drive for the selected digit.
REQ-011 Dig_Sel  out  N_DIG  physical digit select, at most one digit active.
REQ-012 Frame_Done  out  1  one-cycle pulse per completed frame.

Function
REQ-013 Load high in cycle t SHALL write Seg_In into the shadow register at edge t+1.
REQ-014 The shadow register SHALL be copied to the active register only at a frame boundary (IDLE->BLANK entry, or end of last SHOW of digit N_DIG-1); never mid-frame.
REQ-015 Load coincident with a frame-boundary edge SHALL write Seg_In to both shadow and active registers (bypass).
REQ-016 FSM states IDLE, BLANK, SHOW; registered outputs.
REQ-017 IDLE: Dig_Sel all inactive, Seg_Out all inactive, digit index 0, timer 0; Enable=1 -> BLANK next cycle.
REQ-018 BLANK: Dig_Sel all inactive, Seg_Out inactive; exactly BLANK cycles, then SHOW.
REQ-019 SHOW: Dig_Sel[index] active, Seg_Out = active pattern of digit index (inverted if ACTIVE_LOW); exactly DIV-BLANK cycles, then BLANK with index+1.
REQ-020 Each digit slot SHALL be exactly DIV cycles; a frame exactly N_DIG*DIV cycles.
REQ-021 Index SHALL wrap N_DIG-1 -> 0; on that edge Frame_Done SHALL be high for exactly the following cycle.
REQ-022 Enable sampled low in any state SHALL force IDLE at the next edge (outputs inactive next cycle); no Frame_Done for the aborted frame.
REQ-023 Enable re-asserted SHALL restart at digit 0 with a full BLANK period.
REQ-024 Timer width SHALL be clog2(DIV); index width clog2(N_DIG); no overflow permitted.

Reset
REQ-025 Rst_n low at an edge SHALL set: state IDLE, index 0, timer 0, shadow and active registers all 0, Frame_Done 0, Seg_Out and Dig_Sel inactive (all 1s when ACTIVE_LOW).
REQ-026 Reset mid-frame SHALL take effect at the next edge regardless of state; Load and Enable ignored while Rst_n low.

Structure
REQ-027 Shared package seg_scan_pkg SHALL hold state encoding, SEG_W=7 and the segments-off constant.
REQ-028 One sub-module scan_timer (slot/dead-time counter with terminal-count flags) SHALL be instantiated; FSM, registers and output polarity stay in seg_scan_mux.

Verification (N_DIG=2, DIV=8, BLANK=2, ACTIVE_LOW=1)
REQ-029 Rst_n low 3 cycles, Enable=1 -> Seg_Out=7'h7F, Dig_Sel=2'b11, Frame_Done=0 throughout reset.
REQ-030 Load {7'h06,7'h3F} then Enable=1 -> 2 cycles dark, 6 cycles Dig_Sel=2'b10/Seg_Out=7'h40, 2 dark, 6 cycles Dig_Sel=2'b01/Seg_Out=7'h79, Frame_Done pulse, repeat every 16 cycles.
REQ-031 Load 7'h5B pairs mid-frame (during digit 0 SHOW) -> current frame unchanged; new patterns from next frame only.
REQ-032 Load asserted exactly on frame-boundary edge -> new pattern shown in digit 0 of the immediately starting frame.
REQ-033 Enable dropped during digit 1 SHOW -> next cycle all outputs inactive, no Frame_Done; re-enable -> restart at digit 0 after 2 dark cycles.
REQ-034 Rst_n pulsed low mid-SHOW -> next cycle reset values of REQ-025; active pattern cleared to 0 (dark digits after re-enable until Load).

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: state encoding,
// segment width and the logical segments-off pattern.
package seg_scan_pkg;

  localparam int unsigned SEG_W = 7;

  // Logical pattern: no segment lit. Physical polarity is applied by seg_drive().
  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StShow  = 2'd2
  } scan_state_e;

  function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] pat,
                                                 input bit               active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// Per-slot cycle counter for the scanner. Counts 0..DIV-1 across one digit slot and
// flags the last dead-time cycle and the last cycle of the slot.
module scan_timer #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic blank_end_o,
  output logic slot_end_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign blank_end_o = (cnt_q == CntW'(BLANK - 1));
  assign slot_end_o  = (cnt_q == CntW'(DIV - 1));

  // Wraps at DIV-1 so the counter never exceeds its clog2(DIV) range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || slot_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: double-buffered digit patterns, a
// blank/show scan FSM per digit slot, and registered physical-polarity outputs.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int unsigned N_DIG      = 2,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned BLANK      = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [SEG_W*N_DIG-1:0] seg_in_i,
  input  logic                   load_i,
  input  logic                   enable_i,
  output logic [SEG_W-1:0]       seg_out_o,
  output logic [N_DIG-1:0]       dig_sel_o,
  output logic                   frame_done_o
);

  localparam int unsigned IdxW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [SEG_W-1:0] SegOffPhys = seg_drive(SEG_OFF, ACTIVE_LOW);
  localparam logic [N_DIG-1:0] DigOffPhys = ACTIVE_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};
  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(N_DIG - 1);

  scan_state_e            state_q;
  logic [IdxW-1:0]        idx_q;
  logic [SEG_W*N_DIG-1:0] shadow_q, active_q;
  logic [SEG_W-1:0]       seg_out_q;
  logic [N_DIG-1:0]       dig_sel_q;
  logic                   frame_done_q;

  logic                   blank_end, slot_end, tmr_clr;
  logic [N_DIG-1:0]       dig_onehot, show_dig;
  logic [SEG_W-1:0]       show_seg;
  logic [SEG_W*N_DIG-1:0] frame_pat;

  assign tmr_clr = (state_q == StIdle) || !enable_i;

  scan_timer #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (tmr_clr),
    .blank_end_o (blank_end),
    .slot_end_o  (slot_end)
  );

  // A load on the boundary edge bypasses the shadow straight into the new frame.
  assign frame_pat = load_i ? seg_in_i : shadow_q;

  always_comb begin
    dig_onehot        = '0;
    dig_onehot[idx_q] = 1'b1;
    show_dig          = ACTIVE_LOW ? ~dig_onehot : dig_onehot;
    show_seg          = seg_drive(active_q[SEG_W*int'(idx_q) +: SEG_W], ACTIVE_LOW);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      seg_out_q    <= SegOffPhys;
      dig_sel_q    <= DigOffPhys;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (load_i) begin
        shadow_q <= seg_in_i;
      end
      unique case (state_q)
        StIdle: begin
          seg_out_q <= SegOffPhys;
          dig_sel_q <= DigOffPhys;
          idx_q     <= '0;
          if (enable_i) begin
            state_q  <= StBlank;
            active_q <= frame_pat;
          end
        end
        StBlank: begin
          if (!enable_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            seg_out_q <= SegOffPhys;
            dig_sel_q <= DigOffPhys;
          end else if (blank_end) begin
            state_q   <= StShow;
            seg_out_q <= show_seg;
            dig_sel_q <= show_dig;
          end else begin
            seg_out_q <= SegOffPhys;
            dig_sel_q <= DigOffPhys;
          end
        end
        StShow: begin
          if (!enable_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            seg_out_q <= SegOffPhys;
            dig_sel_q <= DigOffPhys;
          end else if (slot_end) begin
            state_q   <= StBlank;
            seg_out_q <= SegOffPhys;
            dig_sel_q <= DigOffPhys;
            if (idx_q == LastIdx) begin
              idx_q        <= '0;
              frame_done_q <= 1'b1;
              active_q     <= frame_pat;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            seg_out_q <= show_seg;
            dig_sel_q <= show_dig;
          end
        end
        default: begin
          state_q   <= StIdle;
          idx_q     <= '0;
          seg_out_q <= SegOffPhys;
          dig_sel_q <= DigOffPhys;
        end
      endcase
    end
  end

  assign seg_out_o    = seg_out_q;
  assign dig_sel_o    = dig_sel_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus random traffic, checked each cycle
// against a frame-position model of the scanned display.
module tb_seg_scan_mux;

  localparam int unsigned N_DIG      = 2;
  localparam int unsigned DIV        = 8;
  localparam int unsigned BLANK      = 2;
  localparam bit          ACTIVE_LOW = 1'b1;
  localparam int          FRAME      = N_DIG * DIV;

  logic        clk = 1'b0;
  logic        rst_n, load, en;
  logic [13:0] seg_in;
  logic [6:0]  seg_out;
  logic [1:0]  dig_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .N_DIG      (N_DIG),
    .DIV        (DIV),
    .BLANK      (BLANK),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .seg_in_i     (seg_in),
    .load_i       (load),
    .enable_i     (en),
    .seg_out_o    (seg_out),
    .dig_sel_o    (dig_sel),
    .frame_done_o (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: whether the display is scanning, and position within the current frame.
  bit         m_run = 1'b0;
  int         m_t   = 0;
  bit         m_fd  = 1'b0;
  logic [6:0] m_shadow[N_DIG];
  logic [6:0] m_active[N_DIG];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit l, input logic [13:0] d);
    bit bnd;
    if (!r) begin
      m_run = 1'b0;
      m_t   = 0;
      m_fd  = 1'b0;
      for (int k = 0; k < N_DIG; k++) begin
        m_shadow[k] = '0;
        m_active[k] = '0;
      end
    end else begin
      bnd  = e && (!m_run || m_t == FRAME - 1);
      m_fd = m_run && e && (m_t == FRAME - 1);
      for (int k = 0; k < N_DIG; k++) begin
        if (bnd) m_active[k] = l ? d[7*k +: 7] : m_shadow[k];
        if (l) m_shadow[k] = d[7*k +: 7];
      end
      if (!e) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit l, input logic [13:0] d);
    logic [6:0] exp_seg;
    logic [1:0] exp_dig;
    int         k;
    rst_n  = r;
    en     = e;
    load   = l;
    seg_in = d;
    @(posedge clk);
    model_edge(r, e, l, d);
    if (!m_run || (m_t % DIV) < BLANK) begin
      exp_seg = 7'h7F;
      exp_dig = 2'b11;
    end else begin
      k       = m_t / DIV;
      exp_seg = ~m_active[k];
      exp_dig = ~(2'b01 << k);
    end
    #1;
    chk("seg_out", 16'(seg_out), 16'(exp_seg));
    chk("dig_sel", 16'(dig_sel), 16'(exp_dig));
    chk("frame_done", 16'(frame_done), 16'(m_fd));
  endtask

  // Run enabled until the model reaches frame position t; bounded.
  task automatic run_until(input int t);
    int guard = 0;
    while (!(m_run && m_t == t)) begin
      if (guard > 4 * FRAME) begin
        n_cmp++;
        n_bad++;
        $error("FAIL wait_pos: observed position %0d expected %0d", m_t, t);
        return;
      end
      tick(1'b1, 1'b1, 1'b0, 14'h0);
      guard++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    load   = 1'b0;
    seg_in = '0;

    // Reset held with enable and loads active: both must be ignored.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 14'($urandom));

    // Load {06,3F} while idle, then scan several frames.
    tick(1'b1, 1'b0, 1'b1, {7'h06, 7'h3F});
    for (int i = 0; i < 3 * FRAME; i++) tick(1'b1, 1'b1, 1'b0, 14'h0);

    // Mid-frame load during digit 0 SHOW: takes effect next frame only.
    run_until(3);
    tick(1'b1, 1'b1, 1'b1, {7'h5B, 7'h5B});
    for (int i = 0; i < 2 * FRAME; i++) tick(1'b1, 1'b1, 1'b0, 14'h0);

    // Load exactly on the frame-boundary edge: bypass into the new frame.
    run_until(FRAME - 1);
    tick(1'b1, 1'b1, 1'b1, {7'h66, 7'h4F});
    for (int i = 0; i < FRAME + 4; i++) tick(1'b1, 1'b1, 1'b0, 14'h0);

    // Enable dropped during digit 1 SHOW, then restarted.
    run_until(DIV + BLANK + 1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 14'h0);
    for (int i = 0; i < FRAME + 4; i++) tick(1'b1, 1'b1, 1'b0, 14'h0);

    // Reset pulse mid-SHOW: active patterns cleared, digits dark until a load.
    run_until(BLANK + 2);
    tick(1'b0, 1'b1, 1'b0, 14'h0);
    for (int i = 0; i < FRAME + 4; i++) tick(1'b1, 1'b1, 1'b0, 14'h0);

    // Random traffic: rare resets, occasional enable drops, frequent loads.
    for (int i = 0; i < 800; i++) begin
      tick(($urandom % 150) != 0, ($urandom % 25) != 0, ($urandom % 6) == 0,
           14'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
